// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder: shared I/D memory responder for the multi-cycle CPU.
// Latches one request, then answers after LATENCY cycles with a one-cycle ready pulse.
module multicycle_mem_responder #(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [WORD_W-1:0] i_data_in,
    output logic [WORD_W-1:0] o_data_out,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata, w_rdata, w_dout_d;
    logic              r_rd, r_wr;
    logic              w_req, w_accept, w_done, w_fault, w_oor, w_busy_d, w_err_d;
    logic [IDX_W-1:0]  w_idx;
    logic [WORD_W-1:0] r_mem [DEPTH];

    assign w_req    = i_mem_read | i_mem_write;
    // A request still held when RESP ends is taken on that same edge
    assign w_accept = w_req && (r_state == S_IDLE || r_state == S_RESP);
    assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_fault  = r_rd & r_wr;
    assign w_oor    = {1'b0, r_addr} >= (ADDR_W+1)'(DEPTH);
    assign w_idx    = r_addr[IDX_W-1:0];
    assign w_rdata  = r_mem[w_idx];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        if (r_state == S_WAIT) w_next = w_done ? S_RESP : S_WAIT;
        else                   w_next = w_req ? S_WAIT : S_IDLE;
    end

    always_comb begin
        w_busy_d = w_accept | (o_busy & ~w_done);
        w_err_d  = w_done & (w_fault | w_oor);
        w_dout_d = (!w_done || w_fault) ? o_data_out :
                   w_oor                ? '0 :
                   r_rd                 ? w_rdata : o_data_out;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_data_out <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'(LATENCY - 1);
                r_addr  <= i_address;
                r_wdata <= i_data_in;
                r_rd    <= i_mem_read;
                r_wr    <= i_mem_write;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            o_ready    <= w_done;
            o_busy     <= w_busy_d;
            o_err      <= w_err_d;
            o_data_out <= w_dout_d;
        end
    end

    // Commit only at completion, so a reset during WAIT leaves the array untouched
    always_ff @(posedge i_clk) begin
        if (w_done && r_wr && !r_rd && !w_oor) r_mem[w_idx] <= r_wdata;
    end
endmodule
